// File: rtl/axil_cmd_master_if.sv
// AXI-lite bus bundle shared by the command master and its slaves (led_ctrl etc.).
// Write channel carries wlast/wstrb so single-beat slaves expecting full AXI fields can sit on it.
`timescale 1ns/1ps
interface AXI_LITE #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic aclk,
    input logic aresetn
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  aclk, aresetn,
        input  awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-lite initiator: one command in, one bus transaction, one response out.
// Optional watchdog abort enabled by defining AXIL_TIMEOUT_EN.
`timescale 1ns/1ps
module axil_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    AXI_LITE.master           axi,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              awvalid_reg, awvalid_next;
    logic              wvalid_reg, wvalid_next;
    logic              bready_reg, bready_next;
    logic              arvalid_reg, arvalid_next;
    logic              rready_reg, rready_next;
    logic              aw_done_reg, aw_done_next;
    logic              w_done_reg, w_done_next;
    logic              cmd_ready_reg, cmd_ready_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]        rsp_resp_reg, rsp_resp_next;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = awvalid_reg && axi.awready;
    assign w_hs  = wvalid_reg  && axi.wready;
    assign b_hs  = bready_reg  && axi.bvalid;
    assign ar_hs = arvalid_reg && axi.arready;
    assign r_hs  = rready_reg  && axi.rvalid;

`ifdef AXIL_TIMEOUT_EN
    logic [15:0] cnt_reg, cnt_next;
    logic        rsp_timeout_reg, rsp_timeout_next;
    logic        busy, expired;

    assign busy    = (state_reg == WR_AW_W) || (state_reg == WR_B) ||
                     (state_reg == RD_AR)   || (state_reg == RD_R);
    // >= rather than == so a handshake that wins at expiry still lets the next phase time out
    assign expired = (cnt_reg >= 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == IDLE) begin
            cnt_next = '0;
        end else if (busy) begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_reg         <= '0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    assign rsp_timeout = rsp_timeout_reg;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign rsp_timeout        = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        bready_next    = bready_reg;
        arvalid_next   = arvalid_reg;
        rready_next    = rready_reg;
        aw_done_next   = aw_done_reg;
        w_done_next    = w_done_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;
`ifdef AXIL_TIMEOUT_EN
        rsp_timeout_next = rsp_timeout_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    addr_next    = cmd_addr;
                    wdata_next   = cmd_wdata;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    if (cmd_write) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WR_AW_W;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = RD_AR;
                    end
                end
            end
            WR_AW_W: begin
                // Address and data channels complete independently, in any order
                if (aw_hs) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (w_hs) begin
                    wvalid_next = 1'b0;
                    w_done_next = 1'b1;
                end
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    bready_next = 1'b1;
                    state_next  = WR_B;
                end
            end
            WR_B: begin
                if (b_hs) begin
                    bready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = '0;
                    rsp_resp_next  = axi.bresp;
                    state_next     = RESP;
                end
            end
            RD_AR: begin
                if (ar_hs) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_R;
                end
            end
            RD_R: begin
                if (r_hs) begin
                    rready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = axi.rdata;
                    rsp_resp_next  = axi.rresp;
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef AXIL_TIMEOUT_EN
        if ((state_next == RESP) && (state_reg != RESP)) begin
            rsp_timeout_next = 1'b0;
        end
        // Abort only when no handshake moved the FSM this cycle
        if (busy && expired && (state_next == state_reg)) begin
            awvalid_next     = 1'b0;
            wvalid_next      = 1'b0;
            bready_next      = 1'b0;
            arvalid_next     = 1'b0;
            rready_next      = 1'b0;
            rsp_valid_next   = 1'b1;
            rsp_rdata_next   = '0;
            rsp_resp_next    = 2'b10;
            rsp_timeout_next = 1'b1;
            state_next       = RESP;
        end
`endif

        cmd_ready_next = (state_next == IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= 2'b00;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            bready_reg    <= bready_next;
            arvalid_reg   <= arvalid_next;
            rready_reg    <= rready_next;
            aw_done_reg   <= aw_done_next;
            w_done_reg    <= w_done_next;
            cmd_ready_reg <= cmd_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_resp_reg  <= rsp_resp_next;
        end
    end

    assign axi.awaddr  = addr_reg;
    assign axi.awvalid = awvalid_reg;
    assign axi.wdata   = wdata_reg;
    assign axi.wstrb   = '1;
    assign axi.wlast   = wvalid_reg;
    assign axi.wvalid  = wvalid_reg;
    assign axi.bready  = bready_reg;
    assign axi.araddr  = addr_reg;
    assign axi.arvalid = arvalid_reg;
    assign axi.rready  = rready_reg;

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_resp  = rsp_resp_reg;

endmodule
